// File: rtl/inst_encoder.sv
// Instruction encoder: packs decoded fields into 8-bit words and streams them
// into program memory through a small FIFO that absorbs memory backpressure.
module inst_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [1:0]        in_rd,
  input  logic [1:0]        in_rs,
  input  logic [7:0]        in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_written,
  output logic [1:0]        state_dbg
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both
  // high at the rising edge; a valid source holds its payload until then.

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  words_q;
  logic               err_q;

  logic [7:0]         enc_word;
  logic               enc_ok;
  logic               fifo_full, fifo_empty;
  logic               accept, push, pop;

  // Immediate fits the field when every bit above the field's sign bit
  // matches that sign bit.
  always_comb begin
    enc_word = 8'h00;
    enc_ok   = 1'b1;
    case (in_opcode)
      4'h0, 4'h1: begin
        enc_word = {in_opcode, in_imm[3:0]};
        enc_ok   = (in_imm[7:3] == 5'b00000) || (in_imm[7:3] == 5'b11111);
      end
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA: begin
        enc_word = {in_opcode, in_rd, in_rs};
        enc_ok   = 1'b1;
      end
      default: begin
        enc_word = {in_opcode, in_rd, in_imm[1:0]};
        enc_ok   = (in_imm[7:1] == 7'b0000000) || (in_imm[7:1] == 7'b1111111);
      end
    endcase
  end

  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        in_ready = !fifo_full;
        mem_we   = !fifo_empty;
        if (in_valid && !fifo_full && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        mem_we = !fifo_empty;
        if (fifo_empty) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dropped tuples still complete the handshake, they just never reach the FIFO.
  assign accept = in_valid && in_ready;
  assign push   = accept && enc_ok;
  assign pop    = mem_we && mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      words_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= enc_word;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (state_q == S_IDLE && start) begin
        addr_q  <= base_addr;
        words_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (pop) begin
          addr_q  <= addr_q + 1'b1;
          words_q <= words_q + 1'b1;
        end
        if (accept && !enc_ok) err_q <= 1'b1;
      end
    end
  end

  assign mem_addr      = addr_q;
  assign mem_wdata     = fifo_mem_q[rd_ptr_q];
  assign err           = err_q;
  assign words_written = words_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus randomized
// programs scored against a field-level reference model.
module tb_inst_encoder;

  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = 4'h0;
  logic [1:0]  in_rd = 2'd0;
  logic [1:0]  in_rs = 2'd0;
  logic [7:0]  in_imm = 8'h00;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready = 1'b0;
  logic        busy, done, err;
  logic [7:0]  words_written;
  logic [1:0]  state_dbg;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } tuple_t;

  tuple_t      prog[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [7:0]  obs_q[$];
  logic [7:0]  obs_addr_q[$];
  int          obs_cyc_q[$];
  logic        exp_err;
  logic [7:0]  exp_cnt;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;
  int          ncyc = 0;
  logic        hold_prev = 1'b0;
  logic [7:0]  hold_addr = 8'h00;
  logic [7:0]  hold_data = 8'h00;

  inst_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs(in_rs), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
    .words_written(words_written), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / memory-side ready ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = 1'($urandom_range(0, 1));
      default: mem_ready = 1'b0;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor: completions, done pulses, hold rule ----------------
  always @(negedge clk) begin
    ncyc++;
    if (!reset) begin
      if (hold_prev) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== hold_addr || mem_wdata !== hold_data) begin
          errors++;
          $display("FAIL hold_stable: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                   mem_we, mem_addr, mem_wdata, hold_addr, hold_data);
        end
      end
      if (mem_we === 1'b1 && mem_ready === 1'b1) begin
        obs_q.push_back(mem_wdata);
        obs_addr_q.push_back(mem_addr);
        obs_cyc_q.push_back(ncyc);
      end
      if (done === 1'b1) done_cnt++;
    end
    hold_prev = !reset && (mem_we === 1'b1) && (mem_ready !== 1'b1);
    hold_addr = mem_addr;
    hold_data = mem_wdata;
  end

  // ---------------- reference model ----------------
  function automatic void build_model(input logic [7:0] base);
    int n;
    int v;
    int low;
    bit ok;
    n = 0;
    exp_q.delete();
    exp_addr_q.delete();
    exp_err = 1'b0;
    foreach (prog[i]) begin
      v = $signed(prog[i].imm);
      if (prog[i].op inside {4'd0, 4'd1}) begin
        ok  = (v >= -8) && (v <= 7);
        low = v & 15;
      end else if (prog[i].op inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10}) begin
        ok  = 1'b1;
        low = int'(prog[i].rd) * 4 + int'(prog[i].rs);
      end else begin
        ok  = (v >= -2) && (v <= 1);
        low = int'(prog[i].rd) * 4 + (v & 3);
      end
      if (ok) begin
        exp_q.push_back(8'(int'(prog[i].op) * 16 + low));
        exp_addr_q.push_back(8'((int'(base) + n) % 256));
        n++;
      end else begin
        exp_err = 1'b1;
      end
    end
    exp_cnt = 8'(n % 256);
  endfunction

  function automatic void add(input logic [3:0] op, input logic [1:0] rd,
                              input logic [1:0] rs, input logic [7:0] imm);
    prog.push_back(tuple_t'{op, rd, rs, imm});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_addr_q.delete();
    obs_cyc_q.delete();
    done_cnt = 0;
  endtask

  // Runs the program in prog from base; stall>0 holds mem_ready low for the
  // first stall cycles and pokes start mid-load (which must be ignored).
  task automatic run_load(input string name, input logic [7:0] base, input int mode,
                          input int stall, input bit gaps);
    int  sent;
    int  acc_stall;
    int  cyc;
    bit  rdy;
    bit  vnow;
    sent = 0;
    acc_stall = 0;
    cyc = 0;
    build_model(base);
    rdy_mode = (stall > 0) ? 2 : mode;
    tick();
    tick();
    clear_obs();
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (sent < prog.size() && cyc < 2000) begin
      if (stall > 0 && cyc == stall) rdy_mode = mode;
      start = (stall > 0 && cyc == stall / 2);
      base_addr = base + 8'h40;
      vnow = !(gaps && $urandom_range(0, 3) == 0);
      in_valid = vnow;
      {in_opcode, in_rd, in_rs, in_imm} = prog[sent];
      in_last = (sent == prog.size() - 1);
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (rdy && vnow) begin
        sent++;
        if (cyc < stall) acc_stall++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
    rdy_mode = mode;
    checks++;
    if (sent != prog.size()) begin
      errors++;
      $display("FAIL %s accept_timeout: got %0d accepted expected %0d", name, sent, prog.size());
    end
    if (stall > 0) begin
      checks++;
      if (acc_stall != ((prog.size() < FIFO_DEPTH) ? prog.size() : FIFO_DEPTH)) begin
        errors++;
        $display("FAIL %s stall_accepts: got %0d expected %0d", name, acc_stall, FIFO_DEPTH);
      end
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 500) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    tick();
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_pulse: got %0d high cycles expected 1", name, done_cnt);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_addr_q[i] !== exp_addr_q[i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got %h@%h expected %h@%h",
                 name, i, obs_q[i], obs_addr_q[i], exp_q[i], exp_addr_q[i]);
      end
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", name, err, exp_err);
    end
    checks++;
    if (words_written !== exp_cnt) begin
      errors++;
      $display("FAIL %s words_written: got %0d expected %0d", name, words_written, exp_cnt);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after_done: got busy=%b in_ready=%b expected 0 0", name, busy, in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got ready=%b we=%b busy=%b done=%b err=%b expected all 0",
               in_ready, mem_we, busy, done, err);
    end
    checks++;
    if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mem_bus: got addr=%h data=%h expected 00 00", mem_addr, mem_wdata);
    end
    checks++;
    if (words_written !== 8'h00) begin
      errors++;
      $display("FAIL reset_words: got %0d expected 0", words_written);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got in_ready=%b busy=%b expected 0 0", in_ready, busy);
    end
  endtask

  task automatic test_single();
    prog.delete();
    add(4'h4, 2'd2, 2'd1, 8'h00);
    run_load("single", 8'h10, 0, 0, 1'b0);
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== 8'h49 || obs_addr_q[0] !== 8'h10) begin
      errors++;
      $display("FAIL single_word: got %0d writes, first %h@%h expected 49@10",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'h00,
               (obs_addr_q.size() > 0) ? obs_addr_q[0] : 8'h00);
    end
  endtask

  task automatic test_latency();
    int cyc;
    rdy_mode = 0;
    tick();
    clear_obs();
    base_addr = 8'h50;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    {in_opcode, in_rd, in_rs, in_imm} = {4'h7, 2'd1, 2'd2, 8'h00};
    in_last = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_load: got ready=%b we=%b busy=%b expected 1 0 1", in_ready, mem_we, busy);
    end
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 8'h76 || mem_addr !== 8'h50) begin
      errors++;
      $display("FAIL latency_next_cycle: got we=%b %h@%h expected 1 76@50", mem_we, mem_wdata, mem_addr);
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    checks++;
    if (done_cnt != 1 || words_written !== 8'd1) begin
      errors++;
      $display("FAIL latency_done: got done=%0d words=%0d expected 1 1", done_cnt, words_written);
    end
  endtask

  task automatic test_ld_st();
    prog.delete();
    add(4'h0, 2'd3, 2'd3, 8'hFD);
    add(4'h1, 2'd0, 2'd0, 8'h07);
    run_load("ld_st", 8'h20, 0, 0, 1'b0);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 8'h0D || obs_q[1] !== 8'h17) begin
      errors++;
      $display("FAIL ld_st_words: got %0d writes expected 0D 17", obs_q.size());
    end
  endtask

  task automatic test_range_drop();
    prog.delete();
    add(4'hE, 2'd3, 2'd0, 8'h01);
    add(4'hE, 2'd3, 2'd0, 8'h02);
    add(4'h3, 2'd0, 2'd3, 8'h00);
    run_load("range_drop", 8'h30, 0, 0, 1'b0);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 8'hED || obs_q[1] !== 8'h33 || err !== 1'b1 ||
        words_written !== 8'd2) begin
      errors++;
      $display("FAIL range_drop_words: got %0d writes err=%b words=%0d expected ED 33 err=1 words=2",
               obs_q.size(), err, words_written);
    end
    prog.delete();
    add(4'h0, 2'd0, 2'd0, 8'h40);
    run_load("drop_last_only", 8'h38, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    prog.delete();
    for (int i = 0; i < 6; i++) add(4'(3 + (i % 5)), 2'(i), 2'(i + 1), 8'h00);
    run_load("backpressure", 8'h60, 0, 10, 1'b0);
  endtask

  task automatic test_wrap();
    prog.delete();
    add(4'h5, 2'd1, 2'd1, 8'h00);
    add(4'h8, 2'd2, 2'd3, 8'h00);
    add(4'hA, 2'd3, 2'd0, 8'h00);
    run_load("wrap", 8'hFE, 0, 0, 1'b0);
    checks++;
    if (obs_addr_q.size() != 3 || obs_addr_q[2] !== 8'h00 || words_written !== 8'd3) begin
      errors++;
      $display("FAIL wrap_addr: got %0d writes words=%0d expected 3 writes ending at 00",
               obs_addr_q.size(), words_written);
    end
  endtask

  task automatic test_back_to_back();
    prog.delete();
    for (int i = 0; i < 8; i++) add(4'h4, 2'(i), 2'(3 - i), 8'h00);
    run_load("back_to_back", 8'h90, 0, 0, 1'b0);
    for (int i = 1; i < obs_cyc_q.size(); i++) begin
      checks++;
      if (obs_cyc_q[i] != obs_cyc_q[i-1] + 1) begin
        errors++;
        $display("FAIL throughput[%0d]: got gap %0d cycles expected 1", i, obs_cyc_q[i] - obs_cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int  sent;
    int  cyc;
    bit  rdy;
    prog.delete();
    for (int i = 0; i < 5; i++) add(4'h6, 2'(i), 2'd1, 8'h00);
    rdy_mode = 0;
    tick();
    clear_obs();
    base_addr = 8'h20;
    start = 1'b1;
    tick();
    start = 1'b0;
    sent = 0;
    cyc = 0;
    while (obs_q.size() < 2 && cyc < 100) begin
      in_valid = (sent < 5);
      {in_opcode, in_rd, in_rs, in_imm} = prog[(sent < 5) ? sent : 4];
      in_last = (sent == 4);
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (rdy && sent < 5) sent++;
      cyc++;
    end
    checks++;
    if (obs_q.size() < 2) begin
      errors++;
      $display("FAIL reset_mid_progress: got %0d writes expected 2 before reset", obs_q.size());
    end
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got we=%b busy=%b ready=%b expected 0 0 0", mem_we, busy, in_ready);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (done_cnt != 0 || words_written !== 8'd0 || obs_q.size() >= 5) begin
      errors++;
      $display("FAIL reset_mid_abort: got done=%0d words=%0d writes=%0d expected 0 0 <5",
               done_cnt, words_written, obs_q.size());
    end
    prog.delete();
    add(4'h7, 2'd2, 2'd2, 8'h00);
    add(4'h2, 2'd1, 2'd0, 8'hFF);
    run_load("after_reset", 8'h80, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int          len;
    logic [7:0]  imm;
    for (int it = 0; it < 12; it++) begin
      prog.delete();
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 2))
          0:       imm = 8'($urandom_range(0, 255));
          1:       imm = 8'($urandom_range(0, 3) - 2);
          default: imm = 8'($urandom_range(0, 15) - 8);
        endcase
        add(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), imm);
      end
      run_load("random", 8'($urandom_range(0, 255)), 1, 0, 1'b1);
    end
    rdy_mode = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_latency();
    test_ld_st();
    test_range_drop();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
